// File: rtl/hex_keypad.sv
// 4x4 hex keypad scanner: walks an active-low row strobe, debounces presses and
// releases on a slow scan tick, and keeps a three-key history for a hex display.
module hex_keypad #(
    parameter int SCAN_DIV       = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [11:0] digits
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] LP_DEBOUNCE = 4'(DEBOUNCE_SCANS);
    localparam logic [SCAN_DIV-1:0] LP_PRESCALE_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

    logic [3:0]          r_colsMeta;
    logic [3:0]          r_colsSync;
    logic [SCAN_DIV-1:0] r_prescale;
    logic [1:0]          r_rowIdx;
    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_candCol;
    logic [3:0]          r_keyCode;
    logic                r_keyValid;
    logic                r_keyDown;
    logic [11:0]         r_digits;

    logic                w_scanTick;
    logic                w_pressed;
    logic [1:0]          w_col;
    logic [3:0]          w_cntInc;
    logic                w_cntDone;
    logic [3:0]          w_candKey;
    logic [1:0]          w_stateNext;
    logic [3:0]          w_cntNext;
    logic [1:0]          w_candColNext;
    logic                w_rowAdvance;
    logic                w_accept;
    logic                w_release;

    // The column lines are asynchronous; nothing downstream looks at cols directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_colsMeta <= 4'b1111;
            r_colsSync <= 4'b1111;
        end else begin
            r_colsMeta <= cols;
            r_colsSync <= r_colsMeta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + LP_PRESCALE_ONE;
        end
    end

    assign w_scanTick = &r_prescale;
    assign w_pressed  = ~&r_colsSync;
    assign w_cntInc   = r_cnt + 4'd1;
    assign w_cntDone  = (w_cntInc == LP_DEBOUNCE);
    assign w_candKey  = {r_rowIdx, r_candCol};

    // Lowest-numbered low column wins when several keys share the strobed row.
    always_comb begin
        w_col = 2'd0;
        if (!r_colsSync[0]) begin
            w_col = 2'd0;
        end else if (!r_colsSync[1]) begin
            w_col = 2'd1;
        end else if (!r_colsSync[2]) begin
            w_col = 2'd2;
        end else if (!r_colsSync[3]) begin
            w_col = 2'd3;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_candColNext = r_candCol;
        w_rowAdvance  = 1'b0;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        if (w_scanTick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pressed) begin
                        w_candColNext = w_col;
                        w_cntNext     = 4'd1;
                        w_stateNext   = ST_DEBOUNCE;
                    end else begin
                        w_rowAdvance  = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_pressed && (w_col == r_candCol)) begin
                        if (w_cntDone) begin
                            w_accept    = 1'b1;
                            w_cntNext   = 4'd0;
                            w_stateNext = ST_PRESSED;
                        end else begin
                            w_cntNext   = w_cntInc;
                        end
                    end else begin
                        w_cntNext    = 4'd0;
                        w_stateNext  = ST_IDLE;
                        w_rowAdvance = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_pressed) begin
                        w_cntNext   = 4'd1;
                        w_stateNext = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A bounce back to pressed resumes the held key without re-announcing it.
                    if (w_pressed) begin
                        w_cntNext   = 4'd0;
                        w_stateNext = ST_PRESSED;
                    end else if (w_cntDone) begin
                        w_release    = 1'b1;
                        w_cntNext    = 4'd0;
                        w_stateNext  = ST_IDLE;
                        w_rowAdvance = 1'b1;
                    end else begin
                        w_cntNext    = w_cntInc;
                    end
                end
                default: begin
                    w_cntNext   = 4'd0;
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_candCol <= 2'd0;
            r_rowIdx  <= 2'd0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_candCol <= w_candColNext;
            if (w_rowAdvance) begin
                r_rowIdx <= r_rowIdx + 2'd1;
            end
        end
    end

    // Code and history move only on acceptance and hold through release and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
            r_keyDown  <= 1'b0;
            r_digits   <= 12'h000;
        end else begin
            r_keyValid <= w_accept;
            if (w_accept) begin
                r_keyCode <= w_candKey;
                r_digits  <= {r_digits[7:0], w_candKey};
                r_keyDown <= 1'b1;
            end else if (w_release) begin
                r_keyDown <= 1'b0;
            end
        end
    end

    assign rows      = ~(4'b0001 << r_rowIdx);
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_down  = r_keyDown;
    assign digits    = r_digits;

endmodule

// File: tb/tb_hex_keypad.sv
// Bench for hex_keypad: a simulated 4x4 key matrix, a tick-level behavioural model
// compared every cycle, and directed scenarios with literal expectations.
module tb_hex_keypad;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 4;
    localparam int PERIOD   = 1 << SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [11:0] digits;

    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int         mCount;
    int         mRow;
    bit         mLocked;
    bit         mCandValid;
    int         mCandCol;
    int         mPressRun;
    int         mReleaseRun;
    logic [3:0] mKeyCode;
    bit         mValid;
    bit         mDown;
    logic [3:0] mHist [3];

    hex_keypad #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .digits(digits)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key shorts its row strobe onto its column line.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic modelTick();
        logic [3:0] low;
        bit pressed;
        int col;
        low = keys[mRow*4 +: 4];
        pressed = (low != 4'b0000);
        col = 0;
        for (int c = 3; c >= 0; c--) if (low[c]) col = c;
        if (!mLocked) begin
            if (!pressed) begin
                mCandValid = 0;
                mRow = (mRow + 1) % 4;
            end else if (!mCandValid) begin
                mCandValid = 1;
                mCandCol = col;
                mPressRun = 1;
            end else if (col != mCandCol) begin
                mCandValid = 0;
                mRow = (mRow + 1) % 4;
            end else begin
                mPressRun++;
                if (mPressRun == DS) begin
                    mLocked = 1;
                    mCandValid = 0;
                    mReleaseRun = 0;
                    mKeyCode = 4'(mRow * 4 + col);
                    mHist[2] = mHist[1];
                    mHist[1] = mHist[0];
                    mHist[0] = mKeyCode;
                    mDown = 1;
                    mValid = 1;
                end
            end
        end else begin
            if (pressed) begin
                mReleaseRun = 0;
            end else begin
                mReleaseRun++;
                if (mReleaseRun == DS) begin
                    mLocked = 0;
                    mDown = 0;
                    mRow = (mRow + 1) % 4;
                end
            end
        end
    endtask

    task automatic modelStep();
        if (rst) begin
            mCount = 0; mRow = 0; mLocked = 0; mCandValid = 0; mCandCol = 0;
            mPressRun = 0; mReleaseRun = 0; mKeyCode = 4'h0; mValid = 0; mDown = 0;
            for (int i = 0; i < 3; i++) mHist[i] = 4'h0;
        end else begin
            mValid = 0;
            if (mCount == PERIOD - 1) modelTick();
            mCount = (mCount + 1) % PERIOD;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
    end

    // Every cycle after the first reset edge, the DUT must agree with the model.
    initial begin
        repeat (2) @(negedge clk);
        forever begin
            checkOutput("rows", {12'h0, rows}, {12'h0, 4'b1111 ^ (4'b0001 << mRow)});
            checkOutput("key_code", {12'h0, key_code}, {12'h0, mKeyCode});
            checkOutput("key_valid", {15'h0, key_valid}, {15'h0, mValid});
            checkOutput("key_down", {15'h0, key_down}, {15'h0, mDown});
            checkOutput("digits", {4'h0, digits}, {4'h0, mHist[2], mHist[1], mHist[0]});
            @(negedge clk);
        end
    end

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitTicks(input int n);
        repeat (PERIOD * n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int nTicks);
        keys = k;
        waitTicks(nTicks);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        logic [15:0] k;
        int sel;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rows", {12'h0, rows}, 16'h000E);
        checkOutput("reset_digits", {4'h0, digits}, 16'h0000);
        checkOutput("reset_code", {12'h0, key_code}, 16'h0000);
        checkOutput("reset_valid", {15'h0, key_valid}, 16'h0000);
        checkOutput("reset_down", {15'h0, key_down}, 16'h0000);
        rst = 1'b0;

        $display("[TB] key 9 held for 10 ticks");
        p0 = pulses;
        applyStimulus(16'h0200, 10);
        checkOutput("k9_pulses", 16'(pulses - p0), 16'd1);
        checkOutput("k9_code", {12'h0, key_code}, 16'h0009);
        checkOutput("k9_digits", {4'h0, digits}, 16'h0009);
        checkOutput("k9_down_held", {15'h0, key_down}, 16'h0001);
        applyStimulus(16'h0000, 3);
        checkOutput("k9_down_3rel", {15'h0, key_down}, 16'h0001);
        waitTicks(1);
        checkOutput("k9_down_4rel", {15'h0, key_down}, 16'h0000);
        waitTicks(2);

        $display("[TB] history sequence 1 2 A F");
        doReset(3);
        applyStimulus(16'h0002, 10); applyStimulus(16'h0000, 6);
        checkOutput("hist_001", {4'h0, digits}, 16'h0001);
        applyStimulus(16'h0004, 10); applyStimulus(16'h0000, 6);
        checkOutput("hist_012", {4'h0, digits}, 16'h0012);
        applyStimulus(16'h0400, 10); applyStimulus(16'h0000, 6);
        checkOutput("hist_12A", {4'h0, digits}, 16'h012A);
        applyStimulus(16'h8000, 10); applyStimulus(16'h0000, 6);
        checkOutput("hist_2AF", {4'h0, digits}, 16'h02AF);
        checkOutput("hist_code", {12'h0, key_code}, 16'h000F);

        $display("[TB] short press on row 3 col 0");
        doReset(3);
        waitTicks(3);
        checkOutput("short_row3", {12'h0, rows}, 16'h0007);
        p0 = pulses;
        applyStimulus(16'h1000, 2);
        applyStimulus(16'h0000, 1);
        checkOutput("short_pulses", 16'(pulses - p0), 16'd0);
        checkOutput("short_row0", {12'h0, rows}, 16'h000E);
        checkOutput("short_down", {15'h0, key_down}, 16'h0000);

        $display("[TB] release bounce while pressed");
        doReset(3);
        p0 = pulses;
        applyStimulus(16'h0020, 8);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0020, 4);
        checkOutput("bounce_pulses", 16'(pulses - p0), 16'd1);
        checkOutput("bounce_down", {15'h0, key_down}, 16'h0001);
        applyStimulus(16'h0000, 6);
        checkOutput("bounce_digits", {4'h0, digits}, 16'h0005);

        $display("[TB] reset during debounce");
        applyStimulus(16'h0100, 3);
        keys = 16'h0000;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstdb_rows", {12'h0, rows}, 16'h000E);
        checkOutput("rstdb_code", {12'h0, key_code}, 16'h0000);
        checkOutput("rstdb_digits", {4'h0, digits}, 16'h0000);
        checkOutput("rstdb_down", {15'h0, key_down}, 16'h0000);
        rst = 1'b0;
        p0 = pulses;
        waitTicks(8);
        checkOutput("rstdb_pulses", 16'(pulses - p0), 16'd0);

        $display("[TB] randomized key activity");
        doReset(2);
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 3);
            k = 16'h0000;
            if (sel == 1) begin
                k[$urandom_range(0, 15)] = 1'b1;
            end else if (sel >= 2) begin
                k[$urandom_range(0, 15)] = 1'b1;
                k[$urandom_range(0, 15)] = 1'b1;
            end
            applyStimulus(k, $urandom_range(1, 8));
        end
        applyStimulus(16'h0000, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
